// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
// Round-robin traffic light controller for NUM_PHASES approaches. Each approach
// is served ALL_RED -> RED_YELLOW -> GREEN -> YELLOW, timed in tick_en strobes.
// Latched pedestrian requests lengthen the next green of their approach and
// raise its walk indication for that whole green.
// Optional build macro: TLC_FLASH_EN adds the flash_req input and a flashing
// yellow state entered at the end of an all-red clearance.
module traffic_phase_controller #(
    parameter int NUM_PHASES   = 2,
    parameter int CNT_W        = 29,
    parameter int T_ALL_RED    = 50000000,
    parameter int T_RED_YELLOW = 200000000,
    parameter int T_GREEN      = 100000000,
    parameter int T_YELLOW     = 100000000,
    parameter int T_PED        = 100000000,
    parameter int T_FLASH      = 50000000,
    localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic [NUM_PHASES-1:0]   ped_req,
`ifdef TLC_FLASH_EN
    input  logic                    flash_req,
`endif
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [NUM_PHASES-1:0]   ped_walk
);

    typedef enum logic [2:0] {
        ST_ALL_RED    = 3'd0,
        ST_RED_YELLOW = 3'd1,
        ST_GREEN      = 3'd2,
        ST_YELLOW     = 3'd3
`ifdef TLC_FLASH_EN
        ,ST_FLASH     = 3'd4
`endif
    } state_t;

    // Timer reload values: a state of N ticks counts N-1 down to 0.
    localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_RY  = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_G   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_GP  = CNT_W'(T_GREEN + T_PED - 1);
    localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(T_YELLOW - 1);
`ifdef TLC_FLASH_EN
    localparam logic [CNT_W-1:0] LD_FL  = CNT_W'(T_FLASH - 1);
`endif
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NUM_PHASES - 1);

    // The extended green must be representable in the timer.
    localparam longint unsigned GP_TICKS = longint'(T_GREEN) + longint'(T_PED);
    localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
    localparam bit              WIDTH_OK = (GP_TICKS <= CNT_MAX);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [NUM_PHASES-1:0]   latch_q, latch_d;
    logic [NUM_PHASES-1:0]   walk_q, walk_d;
    logic [NUM_PHASES-1:0]   latch_clr;
    logic [NUM_PHASES-1:0]   sel;
    logic [3*NUM_PHASES-1:0] lights_c;
    logic                    expire;
`ifdef TLC_FLASH_EN
    logic                    flash_on_q, flash_on_d;
`endif

    // One-hot select of the approach that currently owns the right of way.
    always_comb begin
        sel = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            sel[p] = (phase_q == PH_W'(p));
        end
    end

    assign expire = tick_en && (timer_q == '0);

    // Next-state, timer reload, phase rotation and pedestrian service.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        phase_d    = phase_q;
        walk_d     = walk_q;
        latch_clr  = '0;
`ifdef TLC_FLASH_EN
        flash_on_d = flash_on_q;
`endif
        if (tick_en && (timer_q != '0)) begin
            timer_d = timer_q - CNT_W'(1);
        end
        case (state_q)
            ST_ALL_RED: begin
                if (expire) begin
`ifdef TLC_FLASH_EN
                    if (flash_req) begin
                        state_d    = ST_FLASH;
                        timer_d    = LD_FL;
                        flash_on_d = 1'b1;
                    end else begin
                        state_d = ST_RED_YELLOW;
                        timer_d = LD_RY;
                    end
`else
                    state_d = ST_RED_YELLOW;
                    timer_d = LD_RY;
`endif
                end
            end
            ST_RED_YELLOW: begin
                if (expire) begin
                    // A latched request of the active approach is consumed here;
                    // a request arriving this same cycle re-arms the latch.
                    state_d   = ST_GREEN;
                    walk_d    = latch_q & sel;
                    latch_clr = latch_q & sel;
                    timer_d   = (|(latch_q & sel)) ? LD_GP : LD_G;
                end
            end
            ST_GREEN: begin
                if (expire) begin
                    state_d = ST_YELLOW;
                    timer_d = LD_Y;
                    walk_d  = '0;
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_d = ST_ALL_RED;
                    timer_d = LD_AR;
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                end
            end
`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                if (expire) begin
                    if (!flash_req) begin
                        state_d    = ST_ALL_RED;
                        timer_d    = LD_AR;
                        phase_d    = '0;
                        flash_on_d = 1'b0;
                    end else begin
                        timer_d    = LD_FL;
                        flash_on_d = ~flash_on_q;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_ALL_RED;
                timer_d = LD_AR;
                phase_d = '0;
                walk_d  = '0;
            end
        endcase
        latch_d = (latch_q & ~latch_clr) | ped_req;
    end

    // State, timer and pedestrian registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ALL_RED;
            timer_q    <= LD_AR;
            phase_q    <= '0;
            latch_q    <= '0;
            walk_q     <= '0;
`ifdef TLC_FLASH_EN
            flash_on_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            phase_q    <= phase_d;
            latch_q    <= latch_d;
            walk_q     <= walk_d;
`ifdef TLC_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    // Light decode from registered state only; non-active approaches stay red.
    always_comb begin
        lights_c = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            lights_c[3*p +: 3] = 3'b100;
            if (sel[p]) begin
                case (state_q)
                    ST_RED_YELLOW: lights_c[3*p +: 3] = 3'b110;
                    ST_GREEN:      lights_c[3*p +: 3] = 3'b001;
                    ST_YELLOW:     lights_c[3*p +: 3] = 3'b010;
                    default:       lights_c[3*p +: 3] = 3'b100;
                endcase
            end
`ifdef TLC_FLASH_EN
            if (state_q == ST_FLASH) begin
                lights_c[3*p +: 3] = flash_on_q ? 3'b010 : 3'b000;
            end
`endif
        end
    end

    assign lights       = lights_c;
    assign active_phase = phase_q;
    assign ped_walk     = walk_q;

    a_width_ok: assert property (@(posedge clk) disable iff (rst) WIDTH_OK);

endmodule
